// File: rtl/button_conditioner.sv
// Two-channel push-button front end: synchronise, debounce and turn presses into
// single-cycle strobes with hold-to-auto-repeat; inc wins ties, dec is deferred one cycle.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic inc_raw,
  input  logic dec_raw,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] H_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [1:0]    INACTIVE = {ACTIVE_LOW, ACTIVE_LOW};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REPEAT = 2'd2
  } rstate_t;

  // Channel index 0 is inc, 1 is dec.
  logic [1:0]    raw_in;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    pressed;
  logic [1:0]    level;
  logic [1:0]    raw_pulse;
  logic [DW-1:0] dcnt       [2];
  logic [RW-1:0] rcnt       [2];
  logic [RW-1:0] rcnt_next  [2];
  rstate_t       state      [2];
  rstate_t       state_next [2];
  logic          dec_pending;

  assign raw_in  = {dec_raw, inc_raw};
  assign pressed = s2 ^ INACTIVE;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= INACTIVE;
      s2 <= INACTIVE;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        level[i] <= 1'b0;
        dcnt[i]  <= '0;
      end else if (pressed[i] == level[i]) begin
        dcnt[i] <= '0;
      end else if (dcnt[i] == D_LAST) begin
        level[i] <= pressed[i];
        dcnt[i]  <= '0;
      end else begin
        dcnt[i] <= dcnt[i] + DW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        state[i] <= ST_IDLE;
        rcnt[i]  <= '0;
      end else begin
        state[i] <= state_next[i];
        rcnt[i]  <= rcnt_next[i];
      end
    end
  end

  // Release beats terminal count, so no strobe is emitted on the release cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_next[i] = state[i];
      rcnt_next[i]  = rcnt[i];
      raw_pulse[i]  = 1'b0;
      case (state[i])
        ST_IDLE: begin
          if (level[i]) begin
            raw_pulse[i]  = 1'b1;
            rcnt_next[i]  = '0;
            state_next[i] = ST_WAIT;
          end else begin
            rcnt_next[i] = '0;
          end
        end
        ST_WAIT: begin
          if (!level[i]) begin
            state_next[i] = ST_IDLE;
          end else if (rcnt[i] == H_LAST) begin
            raw_pulse[i]  = 1'b1;
            rcnt_next[i]  = '0;
            state_next[i] = ST_REPEAT;
          end else begin
            rcnt_next[i] = rcnt[i] + RW'(1);
          end
        end
        ST_REPEAT: begin
          if (!level[i]) begin
            state_next[i] = ST_IDLE;
          end else if (rcnt[i] == R_LAST) begin
            raw_pulse[i] = 1'b1;
            rcnt_next[i] = '0;
          end else begin
            rcnt_next[i] = rcnt[i] + RW'(1);
          end
        end
        default: begin
          state_next[i] = ST_IDLE;
          rcnt_next[i]  = '0;
        end
      endcase
    end
  end

  // Output strobes; a dec strobe colliding with inc is parked for exactly one cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      inc_pulse   <= 1'b0;
      dec_pulse   <= 1'b0;
      dec_pending <= 1'b0;
    end else begin
      inc_pulse <= raw_pulse[0];
      if (dec_pending) begin
        dec_pulse   <= 1'b1;
        dec_pending <= 1'b0;
      end else if (raw_pulse[0] && raw_pulse[1]) begin
        dec_pulse   <= 1'b0;
        dec_pending <= 1'b1;
      end else begin
        dec_pulse   <= raw_pulse[1];
        dec_pending <= 1'b0;
      end
    end
  end

  assign inc_level = level[0];
  assign dec_level = level[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (D=4, H=20, R=8, active-low keys) with a
// behavioural model compared every cycle plus hand-computed edge expectations.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic inc_raw = 1'b1;
  logic dec_raw = 1'b1;
  logic inc_pulse, dec_pulse, inc_level, dec_level;

  int n_checks = 0;
  int n_fail = 0;
  bit model_on = 1'b0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .inc_raw(inc_raw),
    .dec_raw(dec_raw),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .inc_level(inc_level),
    .dec_level(dec_level)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  // Per channel: pressed-sample history (2-stage sync delay), run length of samples
  // disagreeing with the level, and how many cycles the level has been held.
  bit m_p1 [2];
  bit m_p2 [2];
  bit m_lvl [2];
  int m_run [2];
  int m_age [2];
  bit m_inc, m_dec, m_pend;

  function automatic bit strobe_due(input int age);
    if (age == 1) return 1'b1;
    if (age == 1 + H) return 1'b1;
    if (age > 1 + H && ((age - 1 - H) % R) == 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clock) begin
    bit rp [2];
    bit now_pressed [2];
    now_pressed[0] = ~inc_raw;
    now_pressed[1] = ~dec_raw;
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_p1[c] = 1'b0; m_p2[c] = 1'b0; m_lvl[c] = 1'b0;
        m_run[c] = 0; m_age[c] = 0;
      end
      m_inc = 1'b0; m_dec = 1'b0; m_pend = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_age[c] = m_lvl[c] ? m_age[c] + 1 : 0;
        rp[c] = m_lvl[c] && strobe_due(m_age[c]);
        m_run[c] = (m_p2[c] != m_lvl[c]) ? m_run[c] + 1 : 0;
        if (m_run[c] == D) begin
          m_lvl[c] = m_p2[c];
          m_run[c] = 0;
        end
        m_p2[c] = m_p1[c];
        m_p1[c] = now_pressed[c];
      end
      m_inc = rp[0];
      if (m_pend) begin
        m_dec = 1'b1; m_pend = 1'b0;
      end else if (rp[0] && rp[1]) begin
        m_dec = 1'b0; m_pend = 1'b1;
      end else begin
        m_dec = rp[1];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (model_on) begin
      n_checks++;
      if ({inc_pulse, dec_pulse, inc_level, dec_level} !== {m_inc, m_dec, m_lvl[0], m_lvl[1]}) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t actual ip/dp/il/dl=%b%b%b%b required=%b%b%b%b",
                 $time, inc_pulse, dec_pulse, inc_level, dec_level,
                 m_inc, m_dec, m_lvl[0], m_lvl[1]);
      end
      n_checks++;
      if (inc_pulse && dec_pulse) begin
        n_fail++;
        $display("FAIL both_pulses t=%0t actual both high required never", $time);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input int e, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s edge=%0d actual=%b required=%b", name, e, act, req);
    end
  endtask

  // Called at a negedge: next posedge becomes edge 1 of the scenario.
  task automatic idle(input int n);
    inc_raw = 1'b1; dec_raw = 1'b1; reset = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    model_on = 1'b1;
    check("reset_inc_level", 0, inc_level, 1'b0);
    check("reset_dec_pulse", 0, dec_pulse, 1'b0);
    idle(4);

    // 1: single press held for 10 samples
    for (int e = 1; e <= 22; e++) begin
      inc_raw = (e <= 10) ? 1'b0 : 1'b1;
      @(negedge clock);
      check("s1_inc_pulse", e, inc_pulse, (e == 7) ? 1'b1 : 1'b0);
      check("s1_inc_level", e, inc_level, (e >= 6 && e < 16) ? 1'b1 : 1'b0);
    end
    idle(4);

    // 2: glitches of 3 samples never accepted
    for (int e = 1; e <= 30; e++) begin
      inc_raw = (((e - 1) % 6) < 3) ? 1'b0 : 1'b1;
      @(negedge clock);
      check("s2_inc_level", e, inc_level, 1'b0);
      check("s2_inc_pulse", e, inc_pulse, 1'b0);
    end
    idle(4);

    // 3: long hold with auto-repeat
    for (int e = 1; e <= 75; e++) begin
      dec_raw = (e <= 60) ? 1'b0 : 1'b1;
      @(negedge clock);
      check("s3_dec_pulse", e, dec_pulse,
            (e == 7 || e == 27 || e == 35 || e == 43 || e == 51 || e == 59) ? 1'b1 : 1'b0);
    end
    idle(4);

    // 4: simultaneous press, dec deferred one cycle
    for (int e = 1; e <= 20; e++) begin
      inc_raw = (e <= 12) ? 1'b0 : 1'b1;
      dec_raw = (e <= 12) ? 1'b0 : 1'b1;
      @(negedge clock);
      check("s4_inc_pulse", e, inc_pulse, (e == 7) ? 1'b1 : 1'b0);
      check("s4_dec_pulse", e, dec_pulse, (e == 8) ? 1'b1 : 1'b0);
    end
    idle(4);

    // 5: reset while held forces a fresh debounce
    for (int e = 1; e <= 25; e++) begin
      inc_raw = 1'b0;
      reset = (e == 10 || e == 11) ? 1'b1 : 1'b0;
      @(negedge clock);
      check("s5_inc_pulse", e, inc_pulse, (e == 7 || e == 18) ? 1'b1 : 1'b0);
      if (e == 10 || e == 11) begin
        check("s5_rst_level", e, inc_level, 1'b0);
        check("s5_rst_dec", e, dec_pulse, 1'b0);
      end
    end
    idle(8);

    // 6: reset discards a pending dec strobe
    for (int e = 1; e <= 18; e++) begin
      inc_raw = 1'b0;
      dec_raw = 1'b0;
      reset = (e == 8) ? 1'b1 : 1'b0;
      @(negedge clock);
      check("s6_inc_pulse", e, inc_pulse, (e == 7 || e == 15) ? 1'b1 : 1'b0);
      check("s6_dec_pulse", e, dec_pulse, (e == 16) ? 1'b1 : 1'b0);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
